serial_tx_8_bit: RTL and testbench

Parallel-to-serial transmitter and the transmit-side counterpart of the team's serial receiver. The receiver is an 8-bit LSB-first shift-in register with a load/enable down-counter. This block accepts one byte over a valid/ready handshake and drives a framed, LSB-first bit stream: start bit, data bits, stop bit. Each bit is held for a programmable number of clocks. It sits between the producer datapath and the serial line feeding the receiver.

---
 rtl/serial_tx_8_bit_pkg.sv | 15 +
 rtl/serial_tx_8_bit_if.sv | 21 ++
 rtl/serial_tx_8_bit_down_counter.sv | 28 ++
 rtl/serial_tx_8_bit.sv | 112 +++++++++++
 tb/tb_serial_tx_8_bit.sv | 176 +++++++++++++++++
 5 files changed

// File: rtl/serial_tx_8_bit_pkg.sv
// Shared types and line levels for the framed serial transmitter.
package serial_tx_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } tx_state_t;

    localparam logic START_BIT  = 1'b0;
    localparam logic STOP_BIT   = 1'b1;
    localparam logic IDLE_LEVEL = 1'b1;

endpackage

// File: rtl/serial_tx_8_bit_if.sv
// Producer-side handshake and serial line bundle for serial_tx_8_bit.
interface serial_tx_8_bit_if #(
    parameter int DATA_BITS = 8
);
    logic [DATA_BITS-1:0] data_in;
    logic                 valid_in;
    logic                 ready_out;
    logic                 serial_out;
    logic                 busy;
    logic                 done;

    modport master (
        output data_in, valid_in,
        input  ready_out, serial_out, busy, done
    );

    modport slave (
        input  data_in, valid_in,
        output ready_out, serial_out, busy, done
    );
endinterface

// File: rtl/serial_tx_8_bit_down_counter.sv
// Loadable down-counter with a zero flag; used for bit period and bit index.
module down_counter #(
    parameter int WIDTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             en,
    input  logic [WIDTH-1:0] init,
    output logic             zero
);
    logic [WIDTH-1:0] count_r;

    // Load has priority over decrement; the owner reloads at zero so no wrap occurs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_r <= '0;
        end else if (load) begin
            count_r <= init;
        end else if (en) begin
            count_r <= count_r - {{(WIDTH-1){1'b0}}, 1'b1};
        end else begin
            count_r <= count_r;
        end
    end

    assign zero = (count_r == '0);
endmodule

// File: rtl/serial_tx_8_bit.sv
// Framed LSB-first serial transmitter: start bit, DATA_BITS data bits, stop bit,
// each held CLKS_PER_BIT clocks, fed by a valid/ready byte handshake.
module serial_tx_8_bit
    import serial_tx_pkg::*;
#(
    parameter int DATA_BITS    = 8,
    parameter int CLKS_PER_BIT = 4
) (
    input  logic            clk,
    input  logic            rst,
    serial_tx_8_bit_if.slave bus
);
    localparam int PER_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int BIT_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

    tx_state_t            state_r, state_s;
    logic [DATA_BITS-1:0] shift_r, shift_s;
    logic                 serial_r, serial_s;
    logic                 done_r, done_s;
    logic                 accept_s, active_s, tick_s, last_bit_s;
    logic                 per_load_s, bit_en_s;

    assign accept_s   = (state_r == IDLE) && bus.valid_in;
    assign active_s   = (state_r != IDLE);
    assign per_load_s = accept_s || (active_s && tick_s);
    assign bit_en_s   = (state_r == DATA) && tick_s && !last_bit_s;

    down_counter #(.WIDTH(PER_W)) u_period (
        .clk  (clk),
        .rst  (rst),
        .load (per_load_s),
        .en   (active_s),
        .init (PER_W'(CLKS_PER_BIT - 1)),
        .zero (tick_s)
    );

    down_counter #(.WIDTH(BIT_W)) u_bitcnt (
        .clk  (clk),
        .rst  (rst),
        .load (accept_s),
        .en   (bit_en_s),
        .init (BIT_W'(DATA_BITS - 1)),
        .zero (last_bit_s)
    );

    // Next state, next shift contents, and the line level they imply.
    always_comb begin
        state_s  = state_r;
        shift_s  = shift_r;
        done_s   = 1'b0;
        serial_s = IDLE_LEVEL;
        case (state_r)
            IDLE: begin
                if (accept_s) begin
                    state_s = START;
                    shift_s = bus.data_in;
                end else begin
                    state_s = IDLE;
                end
            end
            START: begin
                if (tick_s) state_s = DATA;
                else        state_s = START;
            end
            DATA: begin
                if (tick_s) begin
                    shift_s = shift_r >> 1'b1;
                    if (last_bit_s) state_s = STOP;
                    else            state_s = DATA;
                end else begin
                    state_s = DATA;
                end
            end
            STOP: begin
                if (tick_s) begin
                    state_s = IDLE;
                    done_s  = 1'b1;
                end else begin
                    state_s = STOP;
                end
            end
            default: state_s = IDLE;
        endcase
        // The line register follows the upcoming state so bits begin the cycle after accept.
        case (state_s)
            START:   serial_s = START_BIT;
            DATA:    serial_s = shift_s[0];
            STOP:    serial_s = STOP_BIT;
            default: serial_s = IDLE_LEVEL;
        endcase
    end

    // State, shift register and registered line/done outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r  <= IDLE;
            shift_r  <= '0;
            serial_r <= IDLE_LEVEL;
            done_r   <= 1'b0;
        end else begin
            state_r  <= state_s;
            shift_r  <= shift_s;
            serial_r <= serial_s;
            done_r   <= done_s;
        end
    end

    assign bus.serial_out = serial_r;
    assign bus.done       = done_r;
    assign bus.busy       = active_s;
    assign bus.ready_out  = (state_r == IDLE);
endmodule

// File: tb/tb_serial_tx_8_bit.sv
// Self-checking bench for serial_tx_8_bit with CLKS_PER_BIT=4 and =1 instances.
module tb_serial_tx_8_bit;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   passed = 0;
    int   total  = 0;

    always #5 clk = ~clk;

    serial_tx_8_bit_if #(.DATA_BITS(8)) if4 ();
    serial_tx_8_bit_if #(.DATA_BITS(8)) if1 ();

    serial_tx_8_bit #(.DATA_BITS(8), .CLKS_PER_BIT(4)) dut4 (
        .clk (clk),
        .rst (rst),
        .bus (if4)
    );

    serial_tx_8_bit #(.DATA_BITS(8), .CLKS_PER_BIT(1)) dut1 (
        .clk (clk),
        .rst (rst),
        .bus (if1)
    );

    typedef struct {
        string      name;
        int         cpb;
        logic [7:0] data;
        int         mode;   // 0: drop valid, scramble data; 1: hold valid with FF; 2: data to 00
        logic [9:0] line;   // bit 9 is the first line bit in time
    } vec_t;

    vec_t vecs[6];

    task automatic chk(input string nm, input logic act, input logic exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %b expected %b at t=%0t", nm, act, exp, $time);
    endtask

    task automatic drive(input int cpb, input logic [7:0] d, input logic v);
        if (cpb == 1) begin
            if1.data_in  = d;
            if1.valid_in = v;
        end else begin
            if4.data_in  = d;
            if4.valid_in = v;
        end
    endtask

    task automatic look(input int cpb, output logic so, output logic rdy,
                        output logic bsy, output logic dn);
        if (cpb == 1) begin
            so = if1.serial_out; rdy = if1.ready_out; bsy = if1.busy; dn = if1.done;
        end else begin
            so = if4.serial_out; rdy = if4.ready_out; bsy = if4.busy; dn = if4.done;
        end
    endtask

    // Reference frame: start 0, data LSB first, stop 1.
    function automatic logic [9:0] model_frame(input logic [7:0] d);
        logic [9:0] p;
        p[9] = 1'b0;
        for (int i = 0; i < 8; i++) p[8-i] = d[i];
        p[0] = 1'b1;
        return p;
    endfunction

    // Called at a negedge; returns at the negedge inside the done cycle.
    task automatic run_frame(input string nm, input int cpb, input logic [7:0] d,
                             input int mode, input logic [9:0] pat);
        logic so, rdy, bsy, dn;
        drive(cpb, d, 1'b1);
        @(posedge clk);
        #1;
        case (mode)
            1:       drive(cpb, 8'hFF, 1'b1);
            2:       drive(cpb, 8'h00, 1'b0);
            default: drive(cpb, 8'($urandom), 1'b0);
        endcase
        for (int k = 0; k <= 10 * cpb; k++) begin
            @(negedge clk);
            look(cpb, so, rdy, bsy, dn);
            if (k < 10 * cpb) begin
                chk({nm, " line"}, so, pat[9 - k / cpb]);
                chk({nm, " busy"}, bsy, 1'b1);
                chk({nm, " ready"}, rdy, 1'b0);
                chk({nm, " done"}, dn, 1'b0);
            end else begin
                chk({nm, " end line"}, so, 1'b1);
                chk({nm, " end busy"}, bsy, 1'b0);
                chk({nm, " end ready"}, rdy, 1'b1);
                chk({nm, " end done"}, dn, 1'b1);
            end
        end
    endtask

    task automatic idle_check(input string nm, input int n);
        logic so, rdy, bsy, dn;
        for (int c = 0; c < n; c++) begin
            @(negedge clk);
            for (int s = 0; s < 2; s++) begin
                look((s == 0) ? 4 : 1, so, rdy, bsy, dn);
                chk({nm, " line"}, so, 1'b1);
                chk({nm, " ready"}, rdy, 1'b1);
                chk({nm, " busy"}, bsy, 1'b0);
                chk({nm, " done"}, dn, 1'b0);
            end
        end
    endtask

    initial begin
        logic so, rdy, bsy, dn;
        int   cpb;
        logic [7:0] d;

        vecs[0] = '{"A5 cpb4",      4, 8'hA5, 0, 10'b0101001011};
        vecs[1] = '{"3C hold FF",   4, 8'h3C, 1, 10'b0001111001};
        vecs[2] = '{"FF b2b",       4, 8'hFF, 0, 10'b0111111111};
        vecs[3] = '{"01 cpb1",      1, 8'h01, 0, 10'b0100000001};
        vecs[4] = '{"F0 data chg",  4, 8'hF0, 2, 10'b0000011111};
        vecs[5] = '{"AA after rst", 4, 8'hAA, 0, 10'b0010101011};

        drive(4, 8'h00, 1'b0);
        drive(1, 8'h00, 1'b0);
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        look(4, so, rdy, bsy, dn);
        chk("reset line", so, 1'b1);
        chk("reset ready", rdy, 1'b1);
        chk("reset busy", bsy, 1'b0);
        chk("reset done", dn, 1'b0);
        rst = 1'b0;
        idle_check("idle", 10);

        for (int v = 0; v < 5; v++)
            run_frame(vecs[v].name, vecs[v].cpb, vecs[v].data, vecs[v].mode, vecs[v].line);
        idle_check("post table", 2);

        // Abort 8'h55 during data bit 3 (cycles 17..20 after accept).
        drive(4, 8'h55, 1'b1);
        @(posedge clk);
        #1 drive(4, 8'h0F, 1'b0);
        repeat (17) @(posedge clk);
        #2;
        look(4, so, rdy, bsy, dn);
        chk("pre-abort line", so, 1'b0);
        chk("pre-abort busy", bsy, 1'b1);
        rst = 1'b1;
        #1;
        look(4, so, rdy, bsy, dn);
        chk("abort line", so, 1'b1);
        chk("abort busy", bsy, 1'b0);
        chk("abort ready", rdy, 1'b1);
        chk("abort done", dn, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        idle_check("after abort", 12);

        run_frame(vecs[5].name, vecs[5].cpb, vecs[5].data, vecs[5].mode, vecs[5].line);

        for (int r = 0; r < 24; r++) begin
            cpb = ($urandom_range(0, 1) == 0) ? 4 : 1;
            d   = 8'($urandom);
            repeat ($urandom_range(0, 3)) @(negedge clk);
            run_frame("rand", cpb, d, 2 * int'($urandom_range(0, 1)), model_frame(d));
        end
        idle_check("final idle", 3);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
